// File: rtl/mcalu_if.sv
// mcalu_if: handshake and data bundle between the execute reservation station (exers),
// the multi-cycle ALU (mcalu) and writeback (wb).
//   exers -> mcalu : exers_mcalu_issue, exers_mcalu_op, exers_robid, exers_rd,
//                    exers_op1, exers_op2
//   mcalu -> exers : mcalu_stall
//   mcalu -> wb    : mcalu_valid, mcalu_error, mcalu_ecause, mcalu_robid, mcalu_rd,
//                    mcalu_result
//   wb    -> mcalu : wb_mcalu_stall
//   rob   -> mcalu : rob_flush
// Modports: master = the environment driving issues/handshakes, slave = the ALU.
interface mcalu_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ROBID_W = 7,
  parameter int unsigned RD_W    = 6
);
  logic               exers_mcalu_issue;
  logic [4:0]         exers_mcalu_op;
  logic [ROBID_W-1:0] exers_robid;
  logic [RD_W-1:0]    exers_rd;
  logic [XLEN-1:0]    exers_op1;
  logic [XLEN-1:0]    exers_op2;

  logic               mcalu_stall;
  logic               mcalu_valid;
  logic               mcalu_error;
  logic [4:0]         mcalu_ecause;
  logic [ROBID_W-1:0] mcalu_robid;
  logic [RD_W-1:0]    mcalu_rd;
  logic [XLEN-1:0]    mcalu_result;

  logic               wb_mcalu_stall;
  logic               rob_flush;

  modport master (
    output exers_mcalu_issue, exers_mcalu_op, exers_robid, exers_rd, exers_op1, exers_op2,
    output wb_mcalu_stall, rob_flush,
    input  mcalu_stall, mcalu_valid, mcalu_error, mcalu_ecause, mcalu_robid, mcalu_rd,
    input  mcalu_result
  );

  modport slave (
    input  exers_mcalu_issue, exers_mcalu_op, exers_robid, exers_rd, exers_op1, exers_op2,
    input  wb_mcalu_stall, rob_flush,
    output mcalu_stall, mcalu_valid, mcalu_error, mcalu_ecause, mcalu_robid, mcalu_rd,
    output mcalu_result
  );
endinterface

// File: rtl/mcalu.sv
// mcalu: XLEN-wide ALU with single-cycle integer ops, bit-find/clear, popcount and an
// iterative radix-2^MUL_BITS multiplier (MUL / MULH / MULHU).
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset
//   bus  - mcalu_if.slave: issue from exers, result/tags/exception to wb, wb back-pressure,
//          ROB flush
// Single-cycle ops land in the registered output stage one cycle after issue. Multiplies
// hold the unit in BUSY for XLEN/MUL_BITS cycles, stalling exers, then land in the same
// output stage. Illegal opcodes take the single-cycle path and report cause 2.
module mcalu #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ROBID_W  = 7,
  parameter int unsigned RD_W     = 6,
  parameter int unsigned MUL_BITS = 2
) (
  input logic    clk,
  input logic    rst,
  mcalu_if.slave bus
);

  localparam int unsigned ShW    = $clog2(XLEN);
  localparam int unsigned NSteps = XLEN / MUL_BITS;
  localparam int unsigned CntW   = (NSteps > 1) ? $clog2(NSteps) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(NSteps - 1);

  localparam logic [4:0] CauseIllegal = 5'd2;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StBusy  = 2'b01,
    StValid = 2'b10
  } state_e;

  state_e state_q, state_d;

  // Output stage
  logic [XLEN-1:0]    result_q, result_d;
  logic               error_q, error_d;
  logic [4:0]         ecause_q, ecause_d;
  logic [ROBID_W-1:0] robid_q, robid_d;
  logic [RD_W-1:0]    rd_q, rd_d;

  // Multiplier state
  logic [2*XLEN-1:0]  acc_q, acc_d;
  logic [2*XLEN-1:0]  mcand_q, mcand_d;   // op1 magnitude, shifted up each step
  logic [XLEN-1:0]    mplier_q, mplier_d; // op2 magnitude, shifted down each step
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               neg_q, neg_d;       // negate the final product
  logic               hi_q, hi_d;         // select the high half

  // ---------------------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------------------
  logic stall;
  logic take;

  assign stall = (state_q == StBusy) | ((state_q == StValid) & bus.wb_mcalu_stall);
  // A flush discards a same-cycle issue, so it never counts as taken.
  assign take  = bus.exers_mcalu_issue & ~stall & ~bus.rob_flush;

  // ---------------------------------------------------------------------------------------
  // Single-cycle datapath and opcode decode
  // ---------------------------------------------------------------------------------------
  logic [4:0]             op;
  logic [XLEN-1:0]        op1, op2;
  logic [ShW-1:0]         shamt;
  logic [XLEN-1:0]        masked;
  logic [XLEN-1:0]        lowbit;
  logic [XLEN-1:0]        pfind_idx;
  logic [XLEN-1:0]        popcnt;
  logic signed [XLEN-1:0] sra_res;
  logic [XLEN-1:0]        alu_res;
  logic                   alu_illegal;
  logic                   is_mul;

  assign op      = bus.exers_mcalu_op;
  assign op1     = bus.exers_op1;
  assign op2     = bus.exers_op2;
  assign shamt   = op2[ShW-1:0];
  assign masked  = op1 & ~op2;
  // Isolates the lowest set bit of masked (two's-complement trick).
  assign lowbit  = masked & (-masked);
  assign sra_res = $signed(op1) >>> shamt;

  always_comb begin
    // Descending scan so the lowest set bit wins; all-ones when nothing is set.
    pfind_idx = '1;
    for (int i = int'(XLEN) - 1; i >= 0; i--) begin
      if (masked[i]) pfind_idx = XLEN'(i);
    end
  end

  always_comb begin
    popcnt = '0;
    for (int i = 0; i < int'(XLEN); i++) begin
      popcnt = popcnt + XLEN'(op1[i]);
    end
  end

  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    is_mul      = 1'b0;
    if (!op[4]) begin
      case (op[2:0])
        3'b000:  alu_res = op[3] ? (op1 - op2) : (op1 + op2);
        3'b001:  alu_res = op1 << shamt;
        3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
        3'b011:  alu_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
        3'b100:  alu_res = op[3] ? {{(XLEN-1){1'b0}}, (op1 == op2)} : (op1 ^ op2);
        3'b101:  alu_res = op[3] ? XLEN'(sra_res) : (op1 >> shamt);
        3'b110:  alu_res = op1 | op2;
        default: alu_res = op1 & op2;
      endcase
    end else begin
      case (op[2:0])
        3'b000:  alu_res = pfind_idx;
        3'b001:  alu_res = op1 & ~lowbit;
        3'b010,
        3'b011,
        3'b100:  is_mul = 1'b1;
        3'b101:  alu_res = popcnt;
        default: alu_illegal = 1'b1;
      endcase
    end
  end

  // ---------------------------------------------------------------------------------------
  // Multiplier operand preparation and iteration step
  // ---------------------------------------------------------------------------------------
  logic              mul_signed;
  logic              op1_neg, op2_neg;
  logic [XLEN-1:0]   op1_mag, op2_mag;
  logic [2*XLEN-1:0] partial;
  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] prod_final;
  logic [XLEN-1:0]   mul_res;

  // Only MULH treats operands as signed; MUL's low half is sign-agnostic.
  assign mul_signed = (op[2:0] == 3'b011);
  assign op1_neg    = mul_signed & op1[XLEN-1];
  assign op2_neg    = mul_signed & op2[XLEN-1];
  assign op1_mag    = op1_neg ? (-op1) : op1;
  assign op2_mag    = op2_neg ? (-op2) : op2;

  always_comb begin
    partial = '0;
    for (int b = 0; b < int'(MUL_BITS); b++) begin
      if (mplier_q[b]) partial = partial + (mcand_q << b);
    end
  end

  assign acc_step   = acc_q + partial;
  assign prod_final = neg_q ? (-acc_step) : acc_step;
  assign mul_res    = hi_q ? prod_final[2*XLEN-1:XLEN] : prod_final[XLEN-1:0];

  // ---------------------------------------------------------------------------------------
  // FSM next-state and register updates
  // ---------------------------------------------------------------------------------------
  logic load;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    error_d  = error_q;
    ecause_d = ecause_q;
    robid_d  = robid_q;
    rd_d     = rd_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    load     = 1'b0;

    case (state_q)
      StIdle: load = take;
      StBusy: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << MUL_BITS;
        mplier_d = mplier_q >> MUL_BITS;
        if (cnt_q == '0) begin
          result_d = mul_res;
          error_d  = 1'b0;
          ecause_d = '0;
          state_d  = StValid;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StValid: begin
        // Retire this cycle unless wb holds us; outputs freeze while it does.
        if (!bus.wb_mcalu_stall) begin
          state_d = StIdle;
          load    = take;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      robid_d = bus.exers_robid;
      rd_d    = bus.exers_rd;
      if (is_mul) begin
        acc_d    = '0;
        mcand_d  = {{XLEN{1'b0}}, op1_mag};
        mplier_d = op2_mag;
        cnt_d    = CntInit;
        neg_d    = op1_neg ^ op2_neg;
        hi_d     = (op[2:0] != 3'b010);
        state_d  = StBusy;
      end else begin
        result_d = alu_res;
        error_d  = alu_illegal;
        ecause_d = alu_illegal ? CauseIllegal : 5'd0;
        state_d  = StValid;
      end
    end

    if (bus.rob_flush) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      result_q <= '0;
      error_q  <= 1'b0;
      ecause_q <= '0;
      robid_q  <= '0;
      rd_q     <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      error_q  <= error_d;
      ecause_q <= ecause_d;
      robid_q  <= robid_d;
      rd_q     <= rd_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------------------
  assign bus.mcalu_stall  = stall;
  assign bus.mcalu_valid  = (state_q == StValid);
  assign bus.mcalu_error  = error_q;
  assign bus.mcalu_ecause = ecause_q;
  assign bus.mcalu_robid  = robid_q;
  assign bus.mcalu_rd     = rd_q;
  assign bus.mcalu_result = result_q;

endmodule

// File: tb/tb_mcalu.sv
// tb_mcalu: directed, scoreboard-checked bench for mcalu (XLEN=32, MUL_BITS=2).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mcalu;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned ROBID_W  = 7;
  localparam int unsigned RD_W     = 6;
  localparam int unsigned MUL_BITS = 2;
  localparam int unsigned NSTEPS   = XLEN / MUL_BITS;

  typedef struct packed {
    logic [ROBID_W-1:0] robid;
    logic [RD_W-1:0]    rd;
    logic [XLEN-1:0]    result;
    logic               error;
    logic [4:0]         ecause;
  } exp_t;

  exp_t sb[$];
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned n_fail = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mcalu_if #(.XLEN(XLEN), .ROBID_W(ROBID_W), .RD_W(RD_W)) bus ();

  mcalu #(.XLEN(XLEN), .ROBID_W(ROBID_W), .RD_W(RD_W), .MUL_BITS(MUL_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Single-cycle op table: opcode, operands, expected result.
  logic [4:0]  v_op [0:13] = '{5'b10000, 5'b10001, 5'b10000, 5'b10101, 5'b01101, 5'b00101,
                               5'b01100, 5'b00010, 5'b00011, 5'b00001, 5'b00100, 5'b00110,
                               5'b00111, 5'b11000};
  logic [31:0] v_a  [0:13] = '{32'h00F0, 32'h00F0, 32'h000F, 32'hF0F0, 32'h80000000,
                               32'h80000000, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,
                               32'hF0F0, 32'h00F0, 32'hF0F0, 32'h0100};
  logic [31:0] v_b  [0:13] = '{32'h0010, 32'h0010, 32'h000F, 32'h0, 32'd4, 32'd36, 32'd5,
                               32'd1, 32'd1, 32'd31, 32'hFF00, 32'h000F, 32'hFF00, 32'h0};
  logic [31:0] v_r  [0:13] = '{32'd5, 32'h00D0, 32'hFFFFFFFF, 32'd8, 32'hF8000000,
                               32'h08000000, 32'd1, 32'd1, 32'd0, 32'h80000000, 32'h0FF0,
                               32'h00FF, 32'hF000, 32'd8};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [4:0] op, input logic [ROBID_W-1:0] robid,
                       input logic [RD_W-1:0] rd, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b);
    bus.exers_mcalu_issue = 1'b1;
    bus.exers_mcalu_op    = op;
    bus.exers_robid       = robid;
    bus.exers_rd          = rd;
    bus.exers_op1         = a;
    bus.exers_op2         = b;
  endtask

  task automatic push(input logic [ROBID_W-1:0] robid, input logic [RD_W-1:0] rd,
                      input logic [XLEN-1:0] result, input logic error,
                      input logic [4:0] ecause);
    exp_t e;
    e.robid  = robid;
    e.rd     = rd;
    e.result = result;
    e.error  = error;
    e.ecause = ecause;
    sb.push_back(e);
  endtask

  // Compare the current output stage against the oldest scoreboard entry.
  task automatic retire(input string tag);
    exp_t e;
    check({tag, "_valid"}, 64'(bus.mcalu_valid), 64'd1);
    check({tag, "_pending"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_result"}, 64'(bus.mcalu_result), 64'(e.result));
      check({tag, "_robid"}, 64'(bus.mcalu_robid), 64'(e.robid));
      check({tag, "_rd"}, 64'(bus.mcalu_rd), 64'(e.rd));
      check({tag, "_error"}, 64'(bus.mcalu_error), 64'(e.error));
      check({tag, "_ecause"}, 64'(bus.mcalu_ecause), 64'(e.ecause));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(bus.mcalu_valid), 64'd0);
    check({tag, "_error"}, 64'(bus.mcalu_error), 64'd0);
    check({tag, "_ecause"}, 64'(bus.mcalu_ecause), 64'd0);
    check({tag, "_robid"}, 64'(bus.mcalu_robid), 64'd0);
    check({tag, "_rd"}, 64'(bus.mcalu_rd), 64'd0);
    check({tag, "_result"}, 64'(bus.mcalu_result), 64'd0);
    check({tag, "_stall"}, 64'(bus.mcalu_stall), 64'd0);
  endtask

  // Issue a multiply at the current falling edge; expect stall for NSTEPS cycles, then
  // the result one cycle later.
  task automatic do_mul(input string tag, input logic [4:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] r,
                        input logic [ROBID_W-1:0] robid, input logic [RD_W-1:0] rd);
    issue(op, robid, rd, a, b);
    push(robid, rd, r, 1'b0, 5'd0);
    @(negedge clk);
    bus.exers_mcalu_issue = 1'b0;
    for (int i = 1; i <= int'(NSTEPS); i++) begin
      check({tag, "_busy"}, 64'({bus.mcalu_stall, bus.mcalu_valid}), 64'(2'b10));
      @(negedge clk);
    end
    retire(tag);
  endtask

  initial begin
    bus.exers_mcalu_issue = 1'b0;
    bus.exers_mcalu_op    = '0;
    bus.exers_robid       = '0;
    bus.exers_rd          = '0;
    bus.exers_op1         = '0;
    bus.exers_op2         = '0;
    bus.wb_mcalu_stall    = 1'b0;
    bus.rob_flush         = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // ADD then SUB back to back
    issue(5'b00000, 7'd1, 6'd2, 32'd5, 32'd7);
    push(7'd1, 6'd2, 32'd12, 1'b0, 5'd0);
    @(negedge clk);
    retire("add");
    issue(5'b01000, 7'd3, 6'd4, 32'd3, 32'd5);
    push(7'd3, 6'd4, 32'hFFFFFFFE, 1'b0, 5'd0);
    @(negedge clk);
    retire("sub");
    bus.exers_mcalu_issue = 1'b0;
    @(negedge clk);
    check("idle_valid", 64'(bus.mcalu_valid), 64'd0);

    // Single-cycle table, one issue per cycle
    for (int i = 0; i <= 14; i++) begin
      if (i > 0) retire($sformatf("tbl%0d", i - 1));
      if (i < 14) begin
        issue(v_op[i], 7'(10 + i), 6'(i), v_a[i], v_b[i]);
        push(7'(10 + i), 6'(i), v_r[i], 1'b0, 5'd0);
      end else begin
        bus.exers_mcalu_issue = 1'b0;
      end
      @(negedge clk);
    end

    // Multiplies, each issued in the cycle the previous one retires
    do_mul("mul", 5'b10010, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 7'd21, 6'd1);
    do_mul("mulh", 5'b10011, 32'h80000000, 32'h80000000, 32'h40000000, 7'd22, 6'd2);
    do_mul("mulhu", 5'b10100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 7'd23, 6'd3);
    do_mul("mulh_neg", 5'b11011, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFF, 7'd24, 6'd4);
    @(negedge clk);
    check("mul_idle", 64'(bus.mcalu_valid), 64'd0);

    // Writeback back-pressure for three cycles with an issue offered meanwhile
    issue(5'b00000, 7'd30, 6'd7, 32'd100, 32'd23);
    push(7'd30, 6'd7, 32'd123, 1'b0, 5'd0);
    @(negedge clk);
    bus.wb_mcalu_stall = 1'b1;
    issue(5'b00000, 7'd31, 6'd8, 32'd1, 32'd1);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("wbs_valid", 64'(bus.mcalu_valid), 64'd1);
      check("wbs_result", 64'(bus.mcalu_result), 64'd123);
      check("wbs_robid", 64'(bus.mcalu_robid), 64'd30);
      check("wbs_stall", 64'(bus.mcalu_stall), 64'd1);
      @(negedge clk);
    end
    bus.wb_mcalu_stall    = 1'b0;
    bus.exers_mcalu_issue = 1'b0;
    retire("wbs_retire");
    @(negedge clk);
    check("wbs_no_accept", 64'(bus.mcalu_valid), 64'd0);

    // Flush at BUSY cycle 8 of a multiply
    issue(5'b10010, 7'd40, 6'd9, 32'd3, 32'd4);
    @(negedge clk);
    bus.exers_mcalu_issue = 1'b0;
    repeat (7) @(negedge clk);
    bus.rob_flush = 1'b1;
    @(negedge clk);
    bus.rob_flush = 1'b0;
    check("flush_busy_stall", 64'(bus.mcalu_stall), 64'd0);
    for (int k = 0; k < 10; k++) begin
      check("flush_busy_valid", 64'(bus.mcalu_valid), 64'd0);
      @(negedge clk);
    end
    do_mul("mul_after_flush", 5'b10010, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 7'd41, 6'd10);

    // Flush discards a same-cycle issue
    bus.rob_flush = 1'b1;
    issue(5'b00000, 7'd42, 6'd11, 32'd1, 32'd2);
    @(negedge clk);
    bus.rob_flush         = 1'b0;
    bus.exers_mcalu_issue = 1'b0;
    check("flush_issue_valid", 64'(bus.mcalu_valid), 64'd0);

    // Flush discards a result held by writeback
    issue(5'b00000, 7'd43, 6'd12, 32'd2, 32'd2);
    @(negedge clk);
    bus.exers_mcalu_issue = 1'b0;
    bus.wb_mcalu_stall    = 1'b1;
    bus.rob_flush         = 1'b1;
    @(negedge clk);
    bus.rob_flush = 1'b0;
    #1;
    check("flush_held_valid", 64'(bus.mcalu_valid), 64'd0);
    check("flush_held_stall", 64'(bus.mcalu_stall), 64'd0);
    bus.wb_mcalu_stall = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of a multiply
    issue(5'b10100, 7'd50, 6'd13, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(negedge clk);
    bus.exers_mcalu_issue = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("rst_lost_mul", 64'(bus.mcalu_valid), 64'd0);
    end

    // Illegal opcodes, back to back
    issue(5'b10110, 7'd5, 6'd6, 32'd123, 32'd456);
    push(7'd5, 6'd6, 32'd0, 1'b1, 5'd2);
    @(negedge clk);
    retire("illegal_110");
    issue(5'b11111, 7'd6, 6'd7, 32'hFFFF, 32'h1);
    push(7'd6, 6'd7, 32'd0, 1'b1, 5'd2);
    @(negedge clk);
    retire("illegal_111");
    issue(5'b00000, 7'd7, 6'd8, 32'd1, 32'd1);
    push(7'd7, 6'd8, 32'd2, 1'b0, 5'd0);
    @(negedge clk);
    retire("legal_after_illegal");
    bus.exers_mcalu_issue = 1'b0;
    @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
